line_responder: RTL and testbench

LINE_RESPONDER -- requirements
Module: line_responder

---
 rtl/lc3b_types.sv | 9 +
 rtl/cline_buffer.sv | 39 +++
 rtl/line_responder.sv | 116 +++++++++++
 tb/tb_line_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b word/line types used by the L2-to-physical-memory responder.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cline;

  localparam int unsigned LC3B_WORDS_PER_LINE = 8;

endpackage

// File: rtl/cline_buffer.sv
// 8x16 line buffer: single-word write by index, full-line load, full-line read.
module cline_buffer
  import lc3b_types::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      we_i,
  input  logic [2:0] widx_i,
  input  lc3b_word  wdata_i,
  input  logic      load_i,
  input  lc3b_cline ldata_i,
  output lc3b_cline line_o
);

  lc3b_word words_q [LC3B_WORDS_PER_LINE];

  // Full-line load takes priority; the responder never asserts both together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LC3B_WORDS_PER_LINE; i++) begin
        words_q[i] <= '0;
      end
    end else if (load_i) begin
      for (int i = 0; i < LC3B_WORDS_PER_LINE; i++) begin
        words_q[i] <= ldata_i[16*i +: 16];
      end
    end else if (we_i) begin
      words_q[widx_i] <= wdata_i;
    end
  end

  always_comb begin
    line_o = '0;
    for (int i = 0; i < LC3B_WORDS_PER_LINE; i++) begin
      line_o[16*i +: 16] = words_q[i];
    end
  end

endmodule

// File: rtl/line_responder.sv
// Serves 128-bit L2 line reads/writes as eight 16-bit physical-memory beats.
module line_responder
  import lc3b_types::*;
#(
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic      clk,
  input  logic      reset_n,
  input  lc3b_word  l2_addr,
  input  logic      l2_read,
  input  logic      l2_write,
  input  lc3b_cline l2_wdata,
  output logic      l2_resp,
  output lc3b_cline l2_rdata,
  output lc3b_word  pmem_addr,
  output logic      pmem_read,
  output logic      pmem_write,
  output lc3b_word  pmem_wdata,
  input  lc3b_word  pmem_rdata,
  input  logic      pmem_resp
);

  typedef enum logic [2:0] {Idle, Read, Write, Resp, Recover} state_e;

  localparam logic [3:0] RecInit = 4'(RECOVER_CYCLES - 1);

  state_e      state_q;
  logic [2:0]  beat_q;
  logic [11:0] line_q;
  logic [3:0]  rec_q;
  logic        resp_q;
  logic        rd_q;
  logic        wr_q;

  logic      buf_we;
  logic      buf_load;
  lc3b_cline buf_line;

  logic unused_addr;
  assign unused_addr = ^l2_addr[3:0];

  // Line load happens on the write-accept edge so later l2_wdata changes are ignored.
  assign buf_load = (state_q == Idle) && !l2_read && l2_write;
  assign buf_we   = (state_q == Read) && pmem_resp;

  cline_buffer u_buf (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .we_i    (buf_we),
    .widx_i  (beat_q),
    .wdata_i (pmem_rdata),
    .load_i  (buf_load),
    .ldata_i (l2_wdata),
    .line_o  (buf_line)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= Idle;
      beat_q  <= '0;
      line_q  <= '0;
      rec_q   <= '0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        Idle: begin
          if (l2_read) begin
            state_q <= Read;
            rd_q    <= 1'b1;
            line_q  <= l2_addr[15:4];
            beat_q  <= '0;
          end else if (l2_write) begin
            state_q <= Write;
            wr_q    <= 1'b1;
            line_q  <= l2_addr[15:4];
            beat_q  <= '0;
          end
        end
        Read, Write: begin
          if (pmem_resp) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) begin
              state_q <= Resp;
              rd_q    <= 1'b0;
              wr_q    <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
        end
        Resp: begin
          state_q <= Recover;
          rec_q   <= RecInit;
        end
        Recover: begin
          if (rec_q == 4'd0) begin
            state_q <= Idle;
          end else begin
            rec_q <= rec_q - 4'd1;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign l2_resp    = resp_q;
  assign l2_rdata   = buf_line;
  assign pmem_read  = rd_q;
  assign pmem_write = wr_q;
  assign pmem_addr  = {line_q, beat_q, 1'b0};
  assign pmem_wdata = buf_line[{beat_q, 4'b0000} +: 16];

endmodule

// File: tb/tb_line_responder.sv
// Directed bench for line_responder with a wait-state programmable pmem model.
module tb_line_responder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  l2_addr;
  logic         l2_read;
  logic         l2_write;
  logic [127:0] l2_wdata;
  logic         l2_resp;
  logic [127:0] l2_rdata;
  logic [15:0]  pmem_addr;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_wdata;
  logic [15:0]  pmem_rdata;
  logic         pmem_resp;

  int total = 0;
  int bad   = 0;

  int ws   = 0;
  int wcnt = 0;

  // Results of the last run_op
  int           n_resp, n_beats, resp_cyc;
  logic         gap, saw_rd, saw_wr, both;
  logic [15:0]  alog [8];
  logic [15:0]  wlog [8];
  logic [127:0] rline;

  always #5 clk = ~clk;

  line_responder #(.RECOVER_CYCLES(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .l2_addr    (l2_addr),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_wdata   (l2_wdata),
    .l2_resp    (l2_resp),
    .l2_rdata   (l2_rdata),
    .pmem_addr  (pmem_addr),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  assign pmem_resp  = (pmem_read || pmem_write) && (wcnt == ws);
  assign pmem_rdata = 16'h1000 + {13'd0, pmem_addr[3:1]};

  always @(posedge clk) begin
    if (pmem_read || pmem_write) wcnt <= pmem_resp ? 0 : wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [15:0] base);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[16*i +: 16] = base + 16'(i);
    return l;
  endfunction

  // Call right after driving a request at a negedge; cycle 1 is the first after the accept edge.
  task automatic run_op(input int budget, input int drop_at);
    int   cyc;
    logic started, done;
    n_resp = 0; n_beats = 0; resp_cyc = 0; gap = 0; saw_rd = 0; saw_wr = 0; both = 0;
    started = 0; done = 0; cyc = 0; rline = '0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (pmem_read) saw_rd = 1;
      if (pmem_write) saw_wr = 1;
      if (pmem_read && pmem_write) both = 1;
      if (pmem_read || pmem_write) started = 1;
      else if (started && n_beats < 8) gap = 1;
      if ((pmem_read || pmem_write) && pmem_resp) begin
        if (n_beats < 8) begin
          alog[n_beats] = pmem_addr;
          wlog[n_beats] = pmem_wdata;
        end
        n_beats++;
        if (n_beats == drop_at) begin
          l2_read = 0;
          l2_write = 0;
        end
      end
      if (l2_resp) begin
        n_resp++;
        resp_cyc = cyc;
        rline = l2_rdata;
        l2_read = 0;
        l2_write = 0;
        done = 1;
      end
    end
    check_eq("op_timeout", {127'd0, done}, 128'd1);
    repeat (6) begin
      @(negedge clk);
      if (l2_resp) n_resp++;
    end
  endtask

  initial begin
    int k;
    logic seen;
    reset_n = 0; l2_addr = '0; l2_read = 0; l2_write = 0; l2_wdata = '1;
    repeat (2) @(negedge clk);
    check_eq("rst_l2_resp", {127'd0, l2_resp}, 128'd0);
    check_eq("rst_l2_rdata", l2_rdata, 128'd0);
    check_eq("rst_pmem_read", {127'd0, pmem_read}, 128'd0);
    check_eq("rst_pmem_write", {127'd0, pmem_write}, 128'd0);
    check_eq("rst_pmem_addr", {112'd0, pmem_addr}, 128'd0);
    check_eq("rst_pmem_wdata", {112'd0, pmem_wdata}, 128'd0);
    reset_n = 1;
    @(negedge clk);

    // Zero-wait read
    ws = 0; l2_addr = 16'h1234; l2_read = 1;
    run_op(100, 99);
    for (int i = 0; i < 8; i++) check_eq("rd_addr", {112'd0, alog[i]}, 128'(16'h1230 + 16'(2*i)));
    check_eq("rd_resp_cycle", 128'(resp_cyc), 128'd9);
    check_eq("rd_line", rline, mk_line(16'h1000));
    check_eq("rd_resp_count", 128'(n_resp), 128'd1);
    check_eq("rd_no_write", {127'd0, saw_wr}, 128'd0);

    // Write with 2 wait states; wdata changed after accept must be ignored
    ws = 2; l2_addr = 16'h4008; l2_write = 1; l2_wdata = mk_line(16'hA0A0);
    @(posedge clk);
    #1 l2_wdata = mk_line(16'h5555);
    run_op(200, 99);
    for (int i = 0; i < 8; i++) begin
      check_eq("wr_data", {112'd0, wlog[i]}, 128'(16'hA0A0 + 16'(i)));
      check_eq("wr_addr", {112'd0, alog[i]}, 128'(16'h4000 + 16'(2*i)));
    end
    check_eq("wr_gap", {127'd0, gap}, 128'd0);
    check_eq("wr_resp_count", 128'(n_resp), 128'd1);
    check_eq("wr_no_read", {127'd0, saw_rd}, 128'd0);
    check_eq("wr_rdata_hold", l2_rdata, mk_line(16'hA0A0));

    // Read and write both requested: read wins
    ws = 1; l2_addr = 16'h2000; l2_read = 1; l2_write = 1; l2_wdata = mk_line(16'hBEEF);
    run_op(200, 99);
    check_eq("both_no_write", {127'd0, saw_wr}, 128'd0);
    check_eq("both_excl", {127'd0, both}, 128'd0);
    check_eq("both_addr0", {112'd0, alog[0]}, 128'h2000);
    check_eq("both_line", rline, mk_line(16'h1000));
    check_eq("both_resp_count", 128'(n_resp), 128'd1);

    // RECOVER_CYCLES=3 with request held past l2_resp
    ws = 0; l2_addr = 16'h3000; l2_read = 1;
    k = 0; seen = 0;
    while (!seen && k < 50) begin
      @(negedge clk); k++;
      if (l2_resp) seen = 1;
    end
    check_eq("rec_first_resp", {127'd0, seen}, 128'd1);
    k = 0; seen = 0;
    while (!seen && k < 50) begin
      @(negedge clk); k++;
      if (pmem_read) seen = 1;
    end
    check_eq("rec_strobe_delay", 128'(k), 128'd5);
    k = 0; seen = 0;
    while (!seen && k < 50) begin
      @(negedge clk); k++;
      if (l2_resp) seen = 1;
    end
    check_eq("rec_second_resp", {127'd0, seen}, 128'd1);
    l2_read = 0;
    repeat (6) @(negedge clk);

    // Reset during beat 4 of a read
    ws = 0; l2_addr = 16'h5550; l2_read = 1;
    repeat (5) @(negedge clk);
    check_eq("abort_beat4_addr", {112'd0, pmem_addr}, 128'h5558);
    reset_n = 0; l2_read = 0;
    #1;
    check_eq("abort_read_low", {127'd0, pmem_read}, 128'd0);
    check_eq("abort_addr_zero", {112'd0, pmem_addr}, 128'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (l2_resp) seen = 1;
    end
    check_eq("abort_no_resp", {127'd0, seen}, 128'd0);
    reset_n = 1;
    @(negedge clk);
    l2_addr = 16'h6660; l2_read = 1;
    run_op(100, 99);
    check_eq("post_rst_addr0", {112'd0, alog[0]}, 128'h6660);
    check_eq("post_rst_resp_cycle", 128'(resp_cyc), 128'd9);
    check_eq("post_rst_line", rline, mk_line(16'h1000));

    // Request dropped after two beats still completes
    ws = 1; l2_addr = 16'h7770; l2_read = 1;
    run_op(200, 2);
    check_eq("drop_beats", 128'(n_beats), 128'd8);
    check_eq("drop_resp_count", 128'(n_resp), 128'd1);
    check_eq("drop_line", rline, mk_line(16'h1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
